// File: rtl/fp_sub_serial_if.sv
// Start/done handshake and operand/result bus for the word-serial modular
// subtractor. The requester uses the master modport, the subtractor the slave.
interface fp_sub_serial_if #(
    parameter int W  = 64,
    parameter int NW = 7
);
    logic            start;
    logic [NW*W-1:0] a;
    logic [NW*W-1:0] b;
    logic [NW*W-1:0] p;
    logic            busy;
    logic            done;
    logic [NW*W-1:0] c;
    logic            borrow_out;

    modport master (
        output start, a, b, p,
        input  busy, done, c, borrow_out
    );

    modport slave (
        input  start, a, b, p,
        output busy, done, c, borrow_out
    );
endinterface

// File: rtl/fp_sub_serial.sv
// Word-serial modular subtractor: c = (a - b) mod p over NW words of W bits.
// A borrow-chained subtract pass runs first; on underflow a carry-chained
// add-back-p pass follows. Operands are held in shift registers so the active
// word is always the low word, and the result shifts in from the top.
// Build option: define FP_SUB_CONST_TIME_EN to always run the add pass (adding
// p masked by the final borrow), giving a fixed 2*NW+1 cycle latency.
// NW must be at least 2.
module fp_sub_serial #(
    parameter int W  = 64,
    parameter int NW = 7
) (
    input logic           clk,
    input logic           rst,
    fp_sub_serial_if.slave bus
);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

    state_t          state;
    logic [NW*W-1:0] a_r;
    logic [NW*W-1:0] b_r;
    logic [NW*W-1:0] p_r;
    logic [NW*W-1:0] d_r;
    logic [IW-1:0]   idx;
    logic            flag;       // borrow in SUB, carry in ADD
    logic            busy_r;
    logic            done_r;
    logic            borrow_r;

    logic [W:0]      sub_w;
    logic [W:0]      add_w;
    logic [W-1:0]    mask;
    logic            last;

    assign last = (idx == IW'(NW - 1));

`ifdef FP_SUB_CONST_TIME_EN
    // Without underflow the add pass contributes zero but still takes its cycles.
    assign mask = {W{borrow_r}};
`else
    assign mask = {W{1'b1}};
`endif

    // One word of subtract and add-back at W+1 bits; the top bit is borrow/carry.
    always_comb begin
        sub_w = {1'b0, a_r[W-1:0]} - {1'b0, b_r[W-1:0]} - {{W{1'b0}}, flag};
        add_w = {1'b0, d_r[W-1:0]} + {1'b0, p_r[W-1:0] & mask} + {{W{1'b0}}, flag};
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            d_r      <= '0;
            idx      <= '0;
            flag     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        p_r      <= bus.p;
                        idx      <= '0;
                        flag     <= 1'b0;
                        borrow_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    d_r <= {sub_w[W-1:0], d_r[NW*W-1:W]};
                    a_r <= a_r >> W;
                    b_r <= b_r >> W;
                    if (last) begin
                        borrow_r <= sub_w[W];
                        idx      <= '0;
                        flag     <= 1'b0;
`ifdef FP_SUB_CONST_TIME_EN
                        state    <= ADD;
`else
                        if (sub_w[W]) begin
                            state <= ADD;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
`endif
                    end else begin
                        flag <= sub_w[W];
                        idx  <= idx + 1'b1;
                    end
                end
                ADD: begin
                    d_r <= {add_w[W-1:0], d_r[NW*W-1:W]};
                    p_r <= p_r >> W;
                    if (last) begin
                        // Final carry is dropped: the result wraps mod 2^(NW*W).
                        flag   <= 1'b0;
                        idx    <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        flag <= add_w[W];
                        idx  <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.c          = d_r;
    assign bus.borrow_out = borrow_r;
endmodule

// File: tb/tb_fp_sub_serial.sv
// Scoreboard bench for fp_sub_serial with W=8, NW=2, p=0x01F7. The driver
// pushes expected result, borrow and latency for each accepted start; a
// negedge monitor pops and compares on every done pulse.
module tb_fp_sub_serial;
    localparam int W  = 8;
    localparam int NW = 2;
    localparam logic [15:0] P = 16'h01F7;
`ifdef FP_SUB_CONST_TIME_EN
    localparam int LAT_NB = 2*NW + 1;
`else
    localparam int LAT_NB = NW + 1;
`endif
    localparam int LAT_B = 2*NW + 1;

    typedef struct {
        logic [15:0] c;
        logic        bo;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;
    logic done_prev;
    exp_t sb[$];

    fp_sub_serial_if #(.W(W), .NW(NW)) bus ();

    fp_sub_serial #(.W(W), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("c", 32'(bus.c), 32'(e.c));
                    chk("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                    chk("done_single", 32'(done_prev), 32'd0);
                end
                busy_cnt = 0;
            end
            done_prev = bus.done;
        end
    end

    // Issue one start (on a negedge) and push its expectation if told to.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit expect_accept);
        exp_t e;
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        if (expect_accept) begin
            e.bo        = (a < b);
            e.c         = (a < b) ? 16'(a - b + P) : 16'(a - b);
            e.lat       = (a < b) ? LAT_B : LAT_NB;
            e.start_cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~a;          // operands are captured; later changes must not matter
        bus.b = ~b;
    endtask

    // Wait for done (bounded), then one more negedge so the next start lands in IDLE.
    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        issue(a, b, 1'b1);
        wait_done();
    endtask

    initial begin
        logic [15:0] ra, rb;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busy_cnt  = 0;
        done_prev = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.p     = P;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_c", 32'(bus.c), 32'd0);
        chk("reset_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        run_op(16'h0100, 16'h0050);   // c=0x00B0, no borrow
        run_op(16'h0050, 16'h0100);   // c=0x0147, borrow
        run_op(16'h0000, 16'h01F6);   // c=0x0001, borrow
        run_op(16'h0123, 16'h0123);   // c=0x0000, no borrow
        run_op(16'h01F6, 16'h0000);   // c=0x01F6, no borrow

        // Start pulsed while busy must be ignored.
        issue(16'h0100, 16'h0050, 1'b1);
        @(negedge clk);
        issue(16'h0123, 16'h0001, 1'b0);
        wait_done();

        // Start in the cycle right after done is accepted (wait_done ends there).
        issue(16'h0050, 16'h0100, 1'b1);
        wait_done();
        issue(16'h0010, 16'h0020, 1'b1);   // c=0x01E7
        wait_done();

        // Reset during the add-back pass abandons the operation.
        sb.delete();
        issue(16'h0050, 16'h0100, 1'b0);   // now at cycle s+1
        @(negedge clk);                    // s+2: SUB word 1
        @(negedge clk);                    // s+3: ADD word 0
        chk("busy_in_add", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_c", 32'(bus.c), 32'd0);
        chk("rst_mid_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);         // monitor flags any stray done
        run_op(16'h0050, 16'h0100);

        // Random regression with a, b < p.
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom_range(32'(P) - 1, 0));
            rb = 16'($urandom_range(32'(P) - 1, 0));
            run_op(ra, rb);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fp_sub_serial.md
Name: fp_sub_serial

Overview:
- Word-serial modular subtractor for the SIKE field datapath: computes c = (a - b) mod p over NW words of W bits each.
- Complements the existing combinational N-bit adder. It performs the subtract pass word by word with a borrow chain. If the subtraction underflows, it runs a conditional add-back-p pass word by word with a carry chain.
- Sits beside the field multiplier and is controlled by the higher-level isogeny/curve-arithmetic FSM through a start/done handshake.

Parameters:
- W, 64, word width in bits.
- NW, 7, number of words; operand width is NW*W (448 bits, enough for p434).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  NW*W  minuend; must satisfy a < p; captured on accepted start.
- b  input  NW*W  subtrahend; must satisfy b < p; captured on accepted start.
- p  input  NW*W  field modulus; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; c is valid in the same cycle.
- c  output  NW*W  result in [0, p); holds until the next accepted start.
- borrow_out  output  1  final borrow of the a - b pass (1 means a < b); valid with done.

Behaviour:
- Reset (async, any state): FSM goes to IDLE; busy=0, done=0, c=0, borrow_out=0; internal borrow/carry, word index and operand registers cleared. An operation in flight is abandoned and no done is emitted.
- IDLE: start=1 captures a, b, p; clears the borrow flag and the word index (i=0); goes to SUB.
- SUB, one word per cycle, i = 0..NW-1:
  - {bw, d_i} = a_i - b_i - bw, computed at width W+1; d_i is written into the result register word i.
  - At i=NW-1 the final bw is latched into borrow_out.
  - If bw=1, go to ADD with i=0 and carry=0; otherwise go to DONE.
- ADD, one word per cycle, i = 0..NW-1:
  - {cy, d_i} = d_i + p_i + cy.
  - The final carry is discarded; the result is mod 2^(NW*W) and lands in [0, p).
  - After i=NW-1, go to DONE.
- DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, c presents the result; then IDLE.
- Latency from the start cycle to the done cycle:
  - NW+1 cycles when a >= b.
  - 2*NW+1 cycles when a < b.
- start while busy or in DONE is ignored; no queuing.
- start in the same cycle that the FSM returns to IDLE (the cycle after done) is accepted normally.
- a = b gives c=0 and borrow_out=0.
- Inputs a, b, p may change freely after capture without affecting the operation in flight.
- Out-of-range inputs (a >= p or b >= p): c = (a - b) mod 2^(NW*W), plus p if borrow; no error flag.

Optional Feature:
- Macro: FP_SUB_CONST_TIME_EN.
- Defined:
  - ADD always executes.
  - Each word adds (p_i AND {W{borrow_out}}) + cy, so a non-underflow adds zero.
  - Latency is fixed at 2*NW+1 cycles regardless of operands (side-channel hardening).
  - Results are identical to the non-const-time build.
- Undefined: ADD is skipped when there is no underflow, as described above.

Test Plan (W=8, NW=2, p=0x01F7):
- a=0x0100, b=0x0050, start -> done 3 cycles later, c=0x00B0, borrow_out=0 (const-time build: 5 cycles, same c).
- a=0x0050, b=0x0100 -> done 5 cycles later, c=0x0147, borrow_out=1; busy high for exactly 4 cycles.
- a=0x0000, b=0x01F6 -> c=0x0001, borrow_out=1. a=b=0x0123 -> c=0x0000, borrow_out=0.
- Pulse start again 2 cycles into an operation, with different a/b -> ignored; the first result is unchanged and only one done pulse occurs. start in the cycle after done -> accepted.
- Assert rst during ADD of a=0x0050, b=0x0100 -> immediately busy=0, done=0, c=0, borrow_out=0; no done appears. A fresh start after reset release produces the correct c=0x0147.
- Randomized regression, 1000 pairs with a, b < p, compared against (a - b + p) % p; also check done is exactly one cycle and latency matches the borrow case.
